// File: rtl/rsa_regs_pkg.sv
// Register map constants, STATUS/CTRL bit positions and FSM state type shared by
// the RSA register controller and its command FSM.
package rsa_regs_pkg;

    localparam int ADDR_STATUS = 0;
    localparam int ADDR_CTRL   = 1;
    localparam int ADDR_SPARE  = 2;
    localparam int P_BASE      = 4;

    // Operand regions follow P_BASE back to back, NW words each
    localparam int REG_P     = 0;
    localparam int REG_E     = 1;
    localparam int REG_M     = 2;
    localparam int REG_CONST = 3;
    localparam int REG_C     = 4;
    localparam int N_OPS     = 4;

    localparam int STS_BUSY   = 0;
    localparam int STS_DONE   = 1;
    localparam int STS_WR_ERR = 2;
    localparam int STS_ABORT  = 3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;

    typedef enum logic {IDLE, BUSY} rsa_state_t;

    function automatic int word_addr(input int region, input int nw, input int k);
        return P_BASE + region * nw + k;
    endfunction

endpackage

// File: rtl/rsa_cmd_fsm.sv
// Command FSM for the RSA core: start/stop pulses, busy state and the sticky
// done / wr_err / abort flags.
module rsa_cmd_fsm
    import rsa_regs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ena_i,
    input  logic ctrl_wr_i,
    input  logic start_i,
    input  logic stop_i,
    input  logic clr_i,
    input  logic op_wr_i,
    input  logic eoc_i,
    output logic busy_o,
    output logic done_o,
    output logic wr_err_o,
    output logic abort_o,
    output logic cap_o,
    output logic rsa_start_o,
    output logic rsa_stop_o
);

    rsa_state_t state_q, state_d;
    logic start_q, start_d, stop_q, stop_d;
    logic done_q, done_d, wr_err_q, wr_err_d, abort_q, abort_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        done_d   = done_q;
        wr_err_d = wr_err_q;
        abort_d  = abort_q;
        cap_o    = 1'b0;
        if (ena_i) begin
            // clr is applied first so any flag set below in the same cycle wins
            if (ctrl_wr_i && clr_i) begin
                done_d   = 1'b0;
                wr_err_d = 1'b0;
                abort_d  = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (ctrl_wr_i && start_i && !stop_i) begin
                        start_d = 1'b1;
                        done_d  = 1'b0;
                        abort_d = 1'b0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (eoc_i) begin
                        cap_o   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (ctrl_wr_i && stop_i) begin
                        stop_d  = 1'b1;
                        abort_d = 1'b1;
                        state_d = IDLE;
                    end
                    if ((ctrl_wr_i && start_i && !stop_i) || op_wr_i) begin
                        wr_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q == BUSY);
    assign done_o      = done_q;
    assign wr_err_o    = wr_err_q;
    assign abort_o     = abort_q;
    assign rsa_start_o = start_q & ena_i;
    assign rsa_stop_o  = stop_q & ena_i;

endmodule

// File: rtl/rsa_reg_ctrl.sv
// Register bank between the spireg port and the RSA core: operand storage with
// write lock, result capture, read mux and registered interrupt.
module rsa_reg_ctrl
    import rsa_regs_pkg::*;
#(
    parameter int REG_W  = 8,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_wdata,
    input  logic              reg_wr_vld,
    output logic [REG_W-1:0]  reg_rdata,
    output logic              rsa_start,
    output logic              rsa_stop,
    output logic [WIDTH-1:0]  rsa_p,
    output logic [WIDTH-1:0]  rsa_e,
    output logic [WIDTH-1:0]  rsa_m,
    output logic [WIDTH-1:0]  rsa_const,
    input  logic [WIDTH-1:0]  rsa_c,
    input  logic              rsa_eoc,
    output logic              irq,
    output logic [REG_W-1:0]  spare
);

    localparam int NW = WIDTH / REG_W;

    if ((WIDTH % REG_W) != 0 || (P_BASE + 5 * NW) > (2 ** ADDR_W)) begin : g_param_err
        $error("rsa_reg_ctrl: WIDTH must be a multiple of REG_W and the map must fit ADDR_W");
    end

    logic [WIDTH-1:0] op_q [N_OPS];
    logic [WIDTH-1:0] op_d [N_OPS];
    logic [WIDTH-1:0] c_q, c_d;
    logic [REG_W-1:0] spare_q, spare_d;
    logic             irq_en_q, irq_en_d, irq_q, irq_d;
    logic             wr, ctrl_wr, op_hit, op_wr;
    logic             busy, done, wr_err, abort, cap;
    logic [REG_W-1:0] status;

    assign wr      = ena & reg_wr_vld;
    assign ctrl_wr = wr && (reg_addr == ADDR_W'(ADDR_CTRL));
    assign op_wr   = wr & op_hit;

    rsa_cmd_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .ena_i      (ena),
        .ctrl_wr_i  (ctrl_wr),
        .start_i    (reg_wdata[CTRL_START]),
        .stop_i     (reg_wdata[CTRL_STOP]),
        .clr_i      (reg_wdata[CTRL_CLR]),
        .op_wr_i    (op_wr),
        .eoc_i      (rsa_eoc),
        .busy_o     (busy),
        .done_o     (done),
        .wr_err_o   (wr_err),
        .abort_o    (abort),
        .cap_o      (cap),
        .rsa_start_o(rsa_start),
        .rsa_stop_o (rsa_stop)
    );

    always_comb begin
        op_d     = op_q;
        c_d      = cap ? rsa_c : c_q;
        spare_d  = spare_q;
        irq_en_d = irq_en_q;
        op_hit   = 1'b0;
        if (ctrl_wr) irq_en_d = reg_wdata[CTRL_IRQ_EN];
        if (wr && reg_addr == ADDR_W'(ADDR_SPARE)) spare_d = reg_wdata;
        // Operand writes are only accepted while the core is idle
        for (int r = 0; r < N_OPS; r++) begin
            for (int k = 0; k < NW; k++) begin
                if (reg_addr == ADDR_W'(word_addr(r, NW, k))) begin
                    op_hit = 1'b1;
                    if (wr && !busy) op_d[r][k*REG_W +: REG_W] = reg_wdata;
                end
            end
        end
        irq_d = irq_en_q & (done | abort);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N_OPS; r++) op_q[r] <= '0;
            c_q      <= '0;
            spare_q  <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else if (ena) begin
            op_q     <= op_d;
            c_q      <= c_d;
            spare_q  <= spare_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        status             = '0;
        status[STS_BUSY]   = busy;
        status[STS_DONE]   = done;
        status[STS_WR_ERR] = wr_err;
        status[STS_ABORT]  = abort;
        reg_rdata = '0;
        if (reg_addr == ADDR_W'(ADDR_STATUS)) reg_rdata = status;
        if (reg_addr == ADDR_W'(ADDR_CTRL))   reg_rdata[CTRL_IRQ_EN] = irq_en_q;
        if (reg_addr == ADDR_W'(ADDR_SPARE))  reg_rdata = spare_q;
        for (int k = 0; k < NW; k++) begin
            for (int r = 0; r < N_OPS; r++) begin
                if (reg_addr == ADDR_W'(word_addr(r, NW, k))) reg_rdata = op_q[r][k*REG_W +: REG_W];
            end
            if (reg_addr == ADDR_W'(word_addr(REG_C, NW, k))) reg_rdata = c_q[k*REG_W +: REG_W];
        end
    end

    assign rsa_p     = op_q[REG_P];
    assign rsa_e     = op_q[REG_E];
    assign rsa_m     = op_q[REG_M];
    assign rsa_const = op_q[REG_CONST];
    assign irq       = irq_q;
    assign spare     = spare_q;

endmodule
